i2c_eeprom_reader: RTL
======================

# i2c_eeprom_reader

Single-byte random-read master for the 16-bit-addressed serial EEPROM on the board's I2C bus; the read counterpart of the existing byte-write controller. On a rising edge of `read` it runs the sequence: START, control byte (write), address high byte, address low byte, repeated START, control byte (read), one data byte, master NACK, STOP. It then presents the byte with a one-cycle valid strobe. It sits beside the writer on the same SCL/SDA pins, and higher-level logic arbitrates between the two by never asserting both requests.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `SCL_HZ`, default 10_000: SCL frequency. `QTR = CLK_HZ/(4*SCL_HZ)` clock cycles per quarter-bit (1250 at defaults).
- `clk_50M` in 1: system clock. One clock domain only.
- `reset_n` in 1: asynchronous, active-low reset.
- `read` in 1: request level. A rising edge starts a transaction.
- `read_control` in 8: device address in `[7:1]`. Bit 0 is ignored; the block sends 0 in the address phase and 1 in the read phase.
- `read_address` in 16: byte address, all 16 bits sent MSB first.
- `read_data` out 8: last byte received. Holds its value until the next successful read.
- `read_valid` out 1: one-cycle pulse when `read_data` is updated.
- `read_complete` out 1: high when idle. Low from accepted edge to end of STOP.
- `ack_error` out 1: set when a slave ACK is missing. Cleared when the next transaction is accepted.
- `i2c_scl` out 1: serial clock, push-pull.
- `i2c_sda` inout 1: open-drain data line. The block drives only 0 or `z`, never 1.

## Operation
- Reset values: `read_complete`=1, `read_valid`=0, `ack_error`=0, `read_data`=8'h00, `i2c_scl`=1, SDA released. All counters and the state register are 0/IDLE.
- Input conditioning:
  - `read` passes through two flops, and the rising edge is taken from them.
  - SDA input passes through a 2-flop synchronizer before any sampling.
- Edge acceptance: an edge is accepted only in IDLE with `read_complete`=1. On acceptance the block latches `read_control`/`read_address`, then clears `read_complete` and `ack_error`. Edges while busy are ignored, not queued.
- States: IDLE → START → TX(ctrl_w) → ACK → TX(addr_hi) → ACK → TX(addr_lo) → ACK → RSTART → TX(ctrl_r) → ACK → RX → NACK → STOP → IDLE.
- Bit slot: 4 quarters.
  - Q0, Q1: SCL=0. SDA is updated on the first cycle of Q0.
  - Q2, Q3: SCL=1.
- TX: 8 bits, MSB first.
- ACK slot: SDA released. Synchronized SDA is sampled on the last cycle of Q2.
  - Sample 0: continue.
  - Sample 1: set `ack_error` and jump to STOP.
- RX: SDA released for 8 slots. Each bit is sampled on the last cycle of Q2 and shifted in MSB first.
- NACK: SDA released for one slot.
- START (4 quarters): SCL=1. SDA released in Q0–Q1, driven 0 in Q2–Q3.
- RSTART (4 quarters): Q0 SCL=0 with SDA released; Q1 SCL=1 with SDA released; Q2–Q3 SCL=1 with SDA=0.
- STOP (4 quarters): Q0 SCL=0 with SDA=0; Q1 SCL=1 with SDA=0; Q2–Q3 SCL=1 with SDA released.
- Completion, on the last cycle of STOP:
  - `read_complete` rises.
  - If no ACK error: `read_data` loads the shift register and `read_valid` pulses in the same cycle.
  - If an ACK error occurred: `read_data` is unchanged and there is no `read_valid`.
- Reset mid-transaction: everything returns to reset values immediately (SCL=1, SDA released). No STOP is generated.

## Timing
- Accept latency: `read` rising edge → `read_complete`=0 is 3 clock edges.
- START begins on the cycle after acceptance.
- Successful transaction: 192 quarters (START 4 + 5 × 9 slots × 4 + RSTART 4 + STOP 4) = 240,000 cycles = 4.8 ms at defaults.
- ACK failure on byte n (1..4): duration is 4 + 36·n + 4 quarters, plus 4 more if the failure is on ctrl_r (RSTART precedes it).
- Quarter counter runs 0..QTR-1 and wraps to 0 exactly at each quarter boundary. There is no drift over the transaction.
- SDA changes only while SCL=0, except in START, RSTART and STOP.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - the `QTR` derivation function;
  - constants `BITS_PER_BYTE`=8 and `QUARTERS_PER_BIT`=4.
- Sub-module `i2c_quarter_timer` produces:
  - a quarter tick;
  - a 2-bit quarter index;
  - a `q2_last` sample strobe.
- It is reusable by the writer. The FSM, shift registers and bit counter stay in the top module.

## Test plan
- Use `SCL_HZ` such that `QTR`=4. Slave model mem[16'h0123]=8'hA5, `read_control`=8'hA0, `read_address`=16'h0123. Expect:
  - bus bytes A0, 01, 23, then Sr, A1;
  - slave returns A5, master NACKs, then STOP;
  - `read_valid` for 1 cycle with `read_data`=8'hA5;
  - `read_complete` high after exactly 192×4 cycles plus accept latency.
- Slave never ACKs the device address → `ack_error`=1, STOP right after slot 9, no `read_valid`, `read_data` unchanged.
- Slave NACKs addr_lo only → `ack_error`=1, STOP after the third ACK slot, no RSTART seen on the bus.
- Second `read` edge mid-transaction → ignored. Exactly one transaction runs. `read_complete` goes low only once.
- `reset_n` pulled low during RX bit 3 → SCL=1 and SDA=z at once, all outputs at reset values. Next request completes normally with 8'hA5.
- Back-to-back reads of addresses 0x0000 (data 8'h00) and 0xFFFF (data 8'hFF) → correct data each time. Bus checker reports no SDA change while SCL=1 outside START, RSTART and STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the board I2C EEPROM controllers: state encoding,
// bit-slot geometry and the quarter-bit period derivation.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX,
    ACK,
    RSTART,
    RX,
    NACK,
    STOP
  } state_t;

  localparam int BITS_PER_BYTE    = 8;
  localparam int QUARTERS_PER_BIT = 4;

  // System clock cycles in one quarter of an SCL period.
  function automatic int qtr_cycles(input int clk_hz, input int scl_hz);
    return clk_hz / (QUARTERS_PER_BIT * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timebase for the I2C masters. While run is high it counts
// 0..QTR-1, wrapping exactly at each quarter boundary, and steps a 2-bit
// quarter index. When run is low it sits at the start of Q0.
module i2c_quarter_timer #(
  parameter int QTR = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       tick,
  output logic [1:0] quarter,
  output logic       q2_last
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] count;

  // tick marks the last cycle of the current quarter
  assign tick    = run && (count == CW'(QTR - 1));
  assign q2_last = tick && (quarter == 2'd2);

  // Cycle counter and quarter index; held at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      quarter <= 2'd0;
    end else if (!run) begin
      count   <= '0;
      quarter <= 2'd0;
    end else if (tick) begin
      count   <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      count   <= count + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_eeprom_reader.sv
// Single-byte random-read master for a 16-bit-addressed I2C EEPROM:
// START, ctrl(W), addr hi, addr lo, Sr, ctrl(R), data, NACK, STOP.
// The result is presented on read_data with a one-cycle read_valid strobe.
module i2c_eeprom_reader
  import i2c_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int SCL_HZ = 10_000
) (
  input  logic        clk_50M,
  input  logic        reset_n,
  input  logic        read,
  input  logic [7:0]  read_control,
  input  logic [15:0] read_address,
  output logic [7:0]  read_data,
  output logic        read_valid,
  output logic        read_complete,
  output logic        ack_error,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  localparam int QTR = qtr_cycles(CLK_HZ, SCL_HZ);

  state_t      state, state_next;
  logic        read_meta, read_sync, read_prev;
  logic        sda_meta, sda_sync;
  logic        tick, q2_last, slot_end, accept;
  logic [1:0]  quarter;
  logic [7:0]  ctrl_lat;
  logic [15:0] addr_lat;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_byte;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic        scl, sda_low;

  i2c_quarter_timer #(
    .QTR(QTR)
  ) u_timer (
    .clk     (clk_50M),
    .rst_n   (reset_n),
    .run     (state != IDLE),
    .tick    (tick),
    .quarter (quarter),
    .q2_last (q2_last)
  );

  assign slot_end = tick && (quarter == 2'd3);
  assign accept   = (state == IDLE) && read_complete && read_sync && !read_prev;

  // Open-drain SDA: only ever pull low or release
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign i2c_scl = scl;

  // Synchronize the request level and the SDA line into clk_50M
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      read_meta <= 1'b0;
      read_sync <= 1'b0;
      read_prev <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
    end else begin
      read_meta <= read;
      read_sync <= read_meta;
      read_prev <= read_sync;
      sda_meta  <= i2c_sda;
      sda_sync  <= sda_meta;
    end
  end

  // State register
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state sequencing and SCL/SDA decode for the current quarter
  always_comb begin
    state_next = state;
    scl        = 1'b1;
    sda_low    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        sda_low = quarter[1];
        if (slot_end) state_next = TX;
      end
      TX: begin
        scl     = quarter[1];
        sda_low = !tx_byte[7];
        if (slot_end && bit_cnt == 3'(BITS_PER_BYTE - 1)) state_next = ACK;
      end
      ACK: begin
        scl = quarter[1];
        if (slot_end) begin
          if (ack_error)               state_next = STOP;
          else if (byte_idx == 2'd2)   state_next = RSTART;
          else if (byte_idx == 2'd3)   state_next = RX;
          else                         state_next = TX;
        end
      end
      RSTART: begin
        scl     = (quarter != 2'd0);
        sda_low = quarter[1];
        if (slot_end) state_next = TX;
      end
      RX: begin
        scl = quarter[1];
        if (slot_end && bit_cnt == 3'(BITS_PER_BYTE - 1)) state_next = NACK;
      end
      NACK: begin
        scl = quarter[1];
        if (slot_end) state_next = STOP;
      end
      STOP: begin
        scl     = (quarter != 2'd0);
        sda_low = !quarter[1];
        if (slot_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, shift registers, bit/byte counters and result handoff
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_lat      <= 8'h00;
      addr_lat      <= 16'h0000;
      tx_byte       <= 8'h00;
      rx_byte       <= 8'h00;
      bit_cnt       <= 3'd0;
      byte_idx      <= 2'd0;
      read_data     <= 8'h00;
      read_valid    <= 1'b0;
      read_complete <= 1'b1;
      ack_error     <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      if (accept) begin
        ctrl_lat      <= read_control;
        addr_lat      <= read_address;
        read_complete <= 1'b0;
        ack_error     <= 1'b0;
      end
      if (state == ACK && q2_last && sda_sync) ack_error <= 1'b1;
      if (state == RX && q2_last) rx_byte <= {rx_byte[6:0], sda_sync};
      if (slot_end) begin
        unique case (state)
          START: begin
            tx_byte  <= ctrl_lat & 8'hFE;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
          end
          TX: begin
            tx_byte <= {tx_byte[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ACK: begin
            tx_byte  <= (byte_idx == 2'd0) ? addr_lat[15:8] : addr_lat[7:0];
            bit_cnt  <= 3'd0;
            byte_idx <= byte_idx + 2'd1;
          end
          RSTART: begin
            tx_byte <= ctrl_lat | 8'h01;
            bit_cnt <= 3'd0;
          end
          RX: begin
            bit_cnt <= bit_cnt + 3'd1;
          end
          STOP: begin
            read_complete <= 1'b1;
            if (!ack_error) begin
              read_data  <= rx_byte;
              read_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
